// File: rtl/rice_riscv_inst_decoder.sv
// rice_riscv_inst_decoder
// Registered RV32I/M/Zicsr instruction decoder sitting between fetch and
// execute. An accepted instruction is decoded combinationally and captured
// into a two-entry buffer (main register M, skid register S), so results
// appear one cycle after acceptance.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_flush             drop every buffered entry (and any same-cycle input)
//   i_valid/o_ready     upstream handshake; i_inst, i_pc carried with it
//   o_valid/i_ready     downstream handshake
//   o_pc, o_op, o_rd, o_rs1, o_rs2, o_imm, o_rd_we, o_illegal
//                       decoded fields of the entry held in M
//   o_illegal_count     saturating count of illegal results handed downstream
module rice_riscv_inst_decoder #(
    parameter int XLEN         = 32,
    parameter bit ENABLE_M     = 1'b1,
    parameter bit ENABLE_ZICSR = 1'b1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [31:0]            i_inst,
    input  logic [XLEN-1:0]        i_pc,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [XLEN-1:0]        o_pc,
    output logic [5:0]             o_op,
    output logic [4:0]             o_rd,
    output logic [4:0]             o_rs1,
    output logic [4:0]             o_rs2,
    output logic [XLEN-1:0]        o_imm,
    output logic                   o_rd_we,
    output logic                   o_illegal,
    output logic [COUNT_WIDTH-1:0] o_illegal_count
);

    localparam logic [5:0] OP_ILLEGAL = 6'd63;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_CSR
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [5:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] dec_op;
    logic       dec_writes;
    imm_fmt_e   dec_fmt;
    logic [31:0] imm32;
    entry_t     dec_entry;

    entry_t     m_entry, s_entry;
    logic       m_valid, s_valid;
    logic [COUNT_WIDTH-1:0] ill_count;
    logic       accept, deliver;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign funct7 = i_inst[31:25];

    // Op classification. The 7-bit opcode cases already require inst[1:0]=11,
    // so compressed encodings fall through to the illegal default.
    always_comb begin
        dec_op     = OP_ILLEGAL;
        dec_fmt    = IMM_NONE;
        dec_writes = 1'b0;
        case (opcode)
            7'h37: begin dec_op = 6'd0; dec_fmt = IMM_U; dec_writes = 1'b1; end
            7'h17: begin dec_op = 6'd1; dec_fmt = IMM_U; dec_writes = 1'b1; end
            7'h6F: begin dec_op = 6'd2; dec_fmt = IMM_J; dec_writes = 1'b1; end
            7'h67: begin
                if (funct3 == 3'd0) dec_op = 6'd3;
                dec_fmt = IMM_I; dec_writes = 1'b1;
            end
            7'h63: begin
                dec_fmt = IMM_B;
                case (funct3)
                    3'd0: dec_op = 6'd4;
                    3'd1: dec_op = 6'd5;
                    3'd4: dec_op = 6'd6;
                    3'd5: dec_op = 6'd7;
                    3'd6: dec_op = 6'd8;
                    3'd7: dec_op = 6'd9;
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            7'h03: begin
                dec_fmt = IMM_I; dec_writes = 1'b1;
                case (funct3)
                    3'd0: dec_op = 6'd10;
                    3'd1: dec_op = 6'd11;
                    3'd2: dec_op = 6'd12;
                    3'd4: dec_op = 6'd13;
                    3'd5: dec_op = 6'd14;
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            7'h23: begin
                dec_fmt = IMM_S;
                case (funct3)
                    3'd0: dec_op = 6'd15;
                    3'd1: dec_op = 6'd16;
                    3'd2: dec_op = 6'd17;
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            7'h13: begin
                dec_fmt = IMM_I; dec_writes = 1'b1;
                case (funct3)
                    3'd0: dec_op = 6'd18;
                    3'd2: dec_op = 6'd19;
                    3'd3: dec_op = 6'd20;
                    3'd4: dec_op = 6'd21;
                    3'd6: dec_op = 6'd22;
                    3'd7: dec_op = 6'd23;
                    3'd1: begin
                        dec_fmt = IMM_SHAMT;
                        if (funct7 == 7'h00) dec_op = 6'd24;
                    end
                    default: begin
                        dec_fmt = IMM_SHAMT;
                        if (funct7 == 7'h00) dec_op = 6'd25;
                        else if (funct7 == 7'h20) dec_op = 6'd26;
                    end
                endcase
            end
            7'h33: begin
                dec_writes = 1'b1;
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'd0: dec_op = 6'd27;
                        3'd1: dec_op = 6'd29;
                        3'd2: dec_op = 6'd30;
                        3'd3: dec_op = 6'd31;
                        3'd4: dec_op = 6'd32;
                        3'd5: dec_op = 6'd33;
                        3'd6: dec_op = 6'd35;
                        default: dec_op = 6'd36;
                    endcase
                end else if (funct7 == 7'h20) begin
                    if (funct3 == 3'd0) dec_op = 6'd28;
                    else if (funct3 == 3'd5) dec_op = 6'd34;
                end else if (funct7 == 7'h01 && ENABLE_M) begin
                    // MUL..REMU occupy 48..55 in funct3 order
                    dec_op = {3'b110, funct3};
                end
            end
            7'h0F: begin
                // FENCE needs fm=0 and rs1=rd=0; FENCE.I only checks funct3
                if (funct3 == 3'd0 && i_inst[31:28] == 4'd0 &&
                    i_inst[19:15] == 5'd0 && i_inst[11:7] == 5'd0)
                    dec_op = 6'd37;
                else if (funct3 == 3'd1)
                    dec_op = 6'd38;
            end
            7'h73: begin
                if (funct3 == 3'd0) begin
                    if (i_inst == 32'h0000_0073)      dec_op = 6'd39;
                    else if (i_inst == 32'h0010_0073) dec_op = 6'd40;
                    else if (i_inst == 32'h3020_0073) dec_op = 6'd41;
                end else if (ENABLE_ZICSR && funct3 != 3'd4) begin
                    dec_fmt = IMM_CSR; dec_writes = 1'b1;
                    case (funct3)
                        3'd1: dec_op = 6'd42;
                        3'd2: dec_op = 6'd43;
                        3'd3: dec_op = 6'd44;
                        3'd5: dec_op = 6'd45;
                        3'd6: dec_op = 6'd46;
                        default: dec_op = 6'd47;
                    endcase
                end
            end
            default: dec_op = OP_ILLEGAL;
        endcase
    end

    // Immediates are built as 32-bit signed values and then sign-extended to
    // XLEN; zero-extended forms (shamt, CSR address) have bit 31 clear.
    always_comb begin
        imm32 = 32'd0;
        case (dec_fmt)
            IMM_I:     imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            IMM_S:     imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            IMM_B:     imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                i_inst[30:25], i_inst[11:8], 1'b0};
            IMM_U:     imm32 = {i_inst[31:12], 12'd0};
            IMM_J:     imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                i_inst[20], i_inst[30:21], 1'b0};
            IMM_SHAMT: imm32 = {27'd0, i_inst[24:20]};
            IMM_CSR:   imm32 = {20'd0, i_inst[31:20]};
            default:   imm32 = 32'd0;
        endcase
    end

    always_comb begin
        dec_entry.pc      = i_pc;
        dec_entry.op      = dec_op;
        dec_entry.rd      = i_inst[11:7];
        dec_entry.rs1     = i_inst[19:15];
        dec_entry.rs2     = i_inst[24:20];
        dec_entry.illegal = (dec_op == OP_ILLEGAL);
        dec_entry.imm     = dec_entry.illegal ? '0 : XLEN'($signed(imm32));
        dec_entry.rd_we   = !dec_entry.illegal && dec_writes && (i_inst[11:7] != 5'd0);
    end

    assign accept  = i_valid && !s_valid;
    assign deliver = m_valid && i_ready;

    // Two-entry buffer. S only fills while M is stalled, so whenever S is
    // valid nothing is accepted and S simply drains into M.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_valid   <= 1'b0;
            s_valid   <= 1'b0;
            m_entry   <= '0;
            s_entry   <= '0;
            ill_count <= '0;
        end else begin
            if (deliver && m_entry.illegal && ill_count != {COUNT_WIDTH{1'b1}})
                ill_count <= ill_count + 1'b1;
            if (i_flush) begin
                m_valid <= 1'b0;
                s_valid <= 1'b0;
            end else if (!m_valid || i_ready) begin
                if (s_valid) begin
                    m_entry <= s_entry;
                    m_valid <= 1'b1;
                    s_valid <= 1'b0;
                end else begin
                    m_valid <= accept;
                    if (accept) m_entry <= dec_entry;
                end
            end else if (accept) begin
                s_entry <= dec_entry;
                s_valid <= 1'b1;
            end
        end
    end

    assign o_ready         = !s_valid;
    assign o_valid         = m_valid;
    assign o_pc            = m_entry.pc;
    assign o_op            = m_entry.op;
    assign o_rd            = m_entry.rd;
    assign o_rs1           = m_entry.rs1;
    assign o_rs2           = m_entry.rs2;
    assign o_imm           = m_entry.imm;
    assign o_rd_we         = m_entry.rd_we;
    assign o_illegal       = m_entry.illegal;
    assign o_illegal_count = ill_count;

endmodule

// File: tb/tb_rice_riscv_inst_decoder.sv
// tb_rice_riscv_inst_decoder
// Drives two decoders from one stimulus stream: dut_a with every extension
// enabled and a 16-bit counter, dut_b with M and Zicsr disabled and a 2-bit
// counter. A rule-table reference decoder plus a queue per DUT supplies the
// expected outputs every cycle; directed literal checks pin key values.
module tb_rice_riscv_inst_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_inst = 32'd0;
    logic [31:0] i_pc = 32'd0;
    logic        i_ready = 1'b0;

    logic        a_ready, a_valid, a_we, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [5:0]  a_op;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [15:0] a_cnt;

    logic        b_ready, b_valid, b_we, b_ill;
    logic [31:0] b_pc, b_imm;
    logic [5:0]  b_op;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [1:0]  b_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rice_riscv_inst_decoder dut_a (
        .i_clk(clk), .i_rst(rst), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(a_ready), .i_inst(i_inst), .i_pc(i_pc), .o_valid(a_valid),
        .i_ready(i_ready), .o_pc(a_pc), .o_op(a_op), .o_rd(a_rd),
        .o_rs1(a_rs1), .o_rs2(a_rs2), .o_imm(a_imm), .o_rd_we(a_we),
        .o_illegal(a_ill), .o_illegal_count(a_cnt)
    );

    rice_riscv_inst_decoder #(
        .XLEN(32), .ENABLE_M(1'b0), .ENABLE_ZICSR(1'b0), .COUNT_WIDTH(2)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(b_ready), .i_inst(i_inst), .i_pc(i_pc), .o_valid(b_valid),
        .i_ready(i_ready), .o_pc(b_pc), .o_op(b_op), .o_rd(b_rd),
        .o_rs1(b_rs1), .o_rs2(b_rs2), .o_imm(b_imm), .o_rd_we(b_we),
        .o_illegal(b_ill), .o_illegal_count(b_cnt)
    );

    // Reference decoder: an ordered list of mask/match rules whose list
    // position is the op index, with an immediate format and a writes-rd flag.
    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        logic [2:0]  fmt;
        logic        we;
        logic [1:0]  grp;
    } rule_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        we;
        logic        ill;
    } exp_t;

    localparam int F_NONE = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5, F_SH = 6, F_C = 7;
    localparam int G_BASE = 0, G_CSR = 1, G_M = 2;

    rule_t rules[$];

    task automatic addRule(input logic [31:0] mask, input logic [31:0] match,
                           input int fmt, input bit we, input int grp);
        rule_t r;
        r.mask = mask; r.match = match; r.fmt = 3'(fmt); r.we = we; r.grp = 2'(grp);
        rules.push_back(r);
    endtask

    task automatic buildRules();
        int br[6] = '{0, 1, 4, 5, 6, 7};
        int ld[5] = '{0, 1, 2, 4, 5};
        int oi[6] = '{0, 2, 3, 4, 6, 7};
        int rf7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
        int rf3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        int cs[6] = '{1, 2, 3, 5, 6, 7};
        addRule(32'h7F, 32'h37, F_U, 1, G_BASE);
        addRule(32'h7F, 32'h17, F_U, 1, G_BASE);
        addRule(32'h7F, 32'h6F, F_J, 1, G_BASE);
        addRule(32'h707F, 32'h67, F_I, 1, G_BASE);
        foreach (br[i]) addRule(32'h707F, 32'h63 | (br[i] << 12), F_B, 0, G_BASE);
        foreach (ld[i]) addRule(32'h707F, 32'h03 | (ld[i] << 12), F_I, 1, G_BASE);
        for (int f = 0; f < 3; f++) addRule(32'h707F, 32'h23 | (f << 12), F_S, 0, G_BASE);
        foreach (oi[i]) addRule(32'h707F, 32'h13 | (oi[i] << 12), F_I, 1, G_BASE);
        addRule(32'hFE00707F, 32'h00001013, F_SH, 1, G_BASE);
        addRule(32'hFE00707F, 32'h00005013, F_SH, 1, G_BASE);
        addRule(32'hFE00707F, 32'h40005013, F_SH, 1, G_BASE);
        foreach (rf3[i]) addRule(32'hFE00707F, (rf7[i] << 25) | (rf3[i] << 12) | 32'h33, F_NONE, 1, G_BASE);
        addRule(32'hF00FFFFF, 32'h0000000F, F_NONE, 0, G_BASE);
        addRule(32'h707F, 32'h100F, F_NONE, 0, G_BASE);
        addRule(32'hFFFFFFFF, 32'h00000073, F_NONE, 0, G_BASE);
        addRule(32'hFFFFFFFF, 32'h00100073, F_NONE, 0, G_BASE);
        addRule(32'hFFFFFFFF, 32'h30200073, F_NONE, 0, G_BASE);
        foreach (cs[i]) addRule(32'h707F, 32'h73 | (cs[i] << 12), F_C, 1, G_CSR);
        for (int f = 0; f < 8; f++) addRule(32'hFE00707F, 32'h02000033 | (f << 12), F_NONE, 1, G_M);
    endtask

    function automatic exp_t refDecode(input logic [31:0] inst, input logic [31:0] pc,
                                       input bit en_m, input bit en_csr);
        exp_t e;
        int s;
        int hit;
        s = int'(inst);
        hit = -1;
        foreach (rules[i])
            if (hit < 0 && (inst & rules[i].mask) == rules[i].match) hit = i;
        if (hit >= 0 && rules[hit].grp == 2'(G_M) && !en_m) hit = -1;
        if (hit >= 0 && rules[hit].grp == 2'(G_CSR) && !en_csr) hit = -1;
        e.pc = pc; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
        if (hit < 0) begin
            e.op = 6'd63; e.imm = 32'd0; e.we = 1'b0; e.ill = 1'b1;
        end else begin
            e.op = 6'(hit); e.ill = 1'b0;
            e.we = rules[hit].we && (inst[11:7] != 5'd0);
            case (int'(rules[hit].fmt))
                F_I:  e.imm = s >>> 20;
                F_S:  e.imm = ((s >>> 25) <<< 5) | int'(inst[11:7]);
                F_B:  e.imm = ((s >>> 31) <<< 12) | (int'(inst[7]) << 11) |
                              (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
                F_U:  e.imm = inst & 32'hFFFFF000;
                F_J:  e.imm = ((s >>> 31) <<< 20) | (int'(inst[19:12]) << 12) |
                              (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
                F_SH: e.imm = 32'(inst[24:20]);
                F_C:  e.imm = 32'(inst[31:20]);
                default: e.imm = 32'd0;
            endcase
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                                 input bit rdy, input bit fl);
        i_valid = v; i_inst = inst; i_pc = pc; i_ready = rdy; i_flush = fl;
        @(negedge clk);
    endtask

    // Behavioural buffer model: a FIFO of at most two decoded entries per DUT.
    exp_t mq[2][$];
    int unsigned mcount[2];
    int unsigned msat[2] = '{65535, 3};

    always @(posedge clk or posedge rst) begin
        bit hs, acc;
        exp_t e;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                mcount[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                hs  = (mq[k].size() > 0) && i_ready;
                acc = i_valid && (mq[k].size() < 2) && !i_flush;
                e   = refDecode(i_inst, i_pc, k == 0, k == 0);
                if (hs && mq[k][0].ill && mcount[k] < msat[k]) mcount[k]++;
                if (i_flush) mq[k].delete();
                else begin
                    if (hs) void'(mq[k].pop_front());
                    if (acc) mq[k].push_back(e);
                end
            end
        end
    end

    task automatic compareDut(input int k, input logic ov, input logic ordy, input logic [31:0] pc,
                              input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic we,
                              input logic ill, input logic [15:0] cnt);
        exp_t e;
        string t;
        t = (k == 0) ? "a" : "b";
        checkOutput({t, ".valid"}, 64'(ov), 64'(mq[k].size() > 0));
        checkOutput({t, ".ready"}, 64'(ordy), 64'(mq[k].size() < 2));
        checkOutput({t, ".count"}, 64'(cnt), 64'(mcount[k]));
        if (mq[k].size() > 0) begin
            e = mq[k][0];
            checkOutput({t, ".pc"}, 64'(pc), 64'(e.pc));
            checkOutput({t, ".op"}, 64'(op), 64'(e.op));
            checkOutput({t, ".rd"}, 64'(rd), 64'(e.rd));
            checkOutput({t, ".rs1"}, 64'(rs1), 64'(e.rs1));
            checkOutput({t, ".rs2"}, 64'(rs2), 64'(e.rs2));
            checkOutput({t, ".imm"}, 64'(imm), 64'(e.imm));
            checkOutput({t, ".rd_we"}, 64'(we), 64'(e.we));
            checkOutput({t, ".illegal"}, 64'(ill), 64'(e.ill));
        end
    endtask

    always @(negedge clk) begin
        compareDut(0, a_valid, a_ready, a_pc, a_op, a_rd, a_rs1, a_rs2, a_imm, a_we, a_ill, a_cnt);
        compareDut(1, b_valid, b_ready, b_pc, b_op, b_rd, b_rs1, b_rs2, b_imm, b_we, b_ill, 16'(b_cnt));
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    localparam logic [31:0] ADDI   = 32'hFFF08293;
    localparam logic [31:0] DIVU   = 32'h025251B3;
    localparam logic [31:0] BEQ    = 32'h00208463;
    localparam logic [31:0] SW     = 32'h00112623;
    localparam logic [31:0] ECALL  = 32'h00000073;
    localparam logic [31:0] CSRRWI = 32'h3002D0F3;

    logic [31:0] vecs[18] = '{
        32'h123450B7, 32'h010000EF, 32'h4071D113, 32'h40628233, 32'h029403B3,
        32'h0220E033, 32'h30200073, 32'h0FF0000F, 32'h0FF0008F, 32'h0000100F,
        32'h00100073, 32'h02001093, 32'hFE209EE3, 32'h00004501, 32'hFF815183,
        32'h342022F3, 32'h00001017, 32'h00000113
    };

    initial begin
        exp_t p;
        buildRules();

        // Hand-computed pins for the reference decoder itself
        p = refDecode(32'h123450B7, 32'd0, 1, 1);
        checkOutput("ref.lui_imm", 64'(p.imm), 64'h12345000);
        p = refDecode(32'h010000EF, 32'd0, 1, 1);
        checkOutput("ref.jal_imm", 64'(p.imm), 64'd16);
        p = refDecode(32'hFE209EE3, 32'd0, 1, 1);
        checkOutput("ref.bne_imm", 64'(p.imm), 64'hFFFFFFFC);
        p = refDecode(32'h0220E033, 32'd0, 1, 1);
        checkOutput("ref.rem_op", 64'(p.op), 64'd54);
        checkOutput("ref.rem_we", 64'(p.we), 64'd0);
        p = refDecode(32'hFF815183, 32'd0, 1, 1);
        checkOutput("ref.lhu_imm", 64'(p.imm), 64'hFFFFFFF8);

        // Reset state
        @(negedge clk); @(negedge clk);
        checkOutput("rst.valid", 64'(a_valid), 64'd0);
        checkOutput("rst.ready", 64'(a_ready), 64'd1);
        checkOutput("rst.op", 64'(a_op), 64'd0);
        checkOutput("rst.imm", 64'(a_imm), 64'd0);
        checkOutput("rst.count", 64'(a_cnt), 64'd0);
        rst = 1'b0;

        // ADDI x5,x1,-1
        applyStimulus(1, ADDI, 32'h100, 1, 0);
        checkOutput("addi.op", 64'(a_op), 64'd18);
        checkOutput("addi.rd", 64'(a_rd), 64'd5);
        checkOutput("addi.rs1", 64'(a_rs1), 64'd1);
        checkOutput("addi.imm", 64'(a_imm), 64'hFFFFFFFF);
        checkOutput("addi.we", 64'(a_we), 64'd1);
        checkOutput("addi.pc", 64'(a_pc), 64'h100);

        // DIVU: legal on dut_a, illegal on dut_b
        applyStimulus(1, DIVU, 32'h104, 1, 0);
        checkOutput("divu.a_op", 64'(a_op), 64'd53);
        checkOutput("divu.a_we", 64'(a_we), 64'd1);
        checkOutput("divu.b_op", 64'(b_op), 64'd63);
        checkOutput("divu.b_ill", 64'(b_ill), 64'd1);
        checkOutput("divu.b_imm", 64'(b_imm), 64'd0);
        checkOutput("divu.b_we", 64'(b_we), 64'd0);
        applyStimulus(0, 32'd0, 32'd0, 1, 0);
        checkOutput("divu.b_count", 64'(b_cnt), 64'd1);
        checkOutput("divu.drained", 64'(a_valid), 64'd0);

        // Back-to-back BEQ, SW with the sink stalled
        applyStimulus(1, BEQ, 32'h200, 0, 0);
        applyStimulus(1, SW, 32'h204, 0, 0);
        checkOutput("stall.ready", 64'(a_ready), 64'd0);
        checkOutput("stall.op", 64'(a_op), 64'd4);
        checkOutput("stall.imm", 64'(a_imm), 64'd8);
        applyStimulus(0, 32'd0, 32'd0, 0, 0);
        checkOutput("stall.hold_op", 64'(a_op), 64'd4);
        checkOutput("stall.hold_pc", 64'(a_pc), 64'h200);
        applyStimulus(0, 32'd0, 32'd0, 1, 0);
        checkOutput("stall.sw_op", 64'(a_op), 64'd17);
        checkOutput("stall.sw_imm", 64'(a_imm), 64'd12);
        checkOutput("stall.ready_back", 64'(a_ready), 64'd1);
        applyStimulus(0, 32'd0, 32'd0, 1, 0);
        checkOutput("stall.empty", 64'(a_valid), 64'd0);

        // Flush with both entries full and a new instruction offered
        applyStimulus(1, ADDI, 32'h300, 0, 0);
        applyStimulus(1, BEQ, 32'h304, 0, 0);
        applyStimulus(1, SW, 32'h308, 0, 1);
        checkOutput("flush.valid", 64'(a_valid), 64'd0);
        checkOutput("flush.ready", 64'(a_ready), 64'd1);
        // Flush in the same cycle as an illegal handshake still counts it
        applyStimulus(1, 32'hFFFFFFFF, 32'h30C, 0, 0);
        applyStimulus(1, SW, 32'h310, 1, 1);
        checkOutput("flush.a_count", 64'(a_cnt), 64'd1);
        checkOutput("flush.b_count", 64'(b_cnt), 64'd2);
        checkOutput("flush.valid2", 64'(a_valid), 64'd0);

        // Illegal stream saturates dut_b's 2-bit counter; ECALL is legal
        applyStimulus(1, 32'h00000000, 32'h320, 1, 0);
        applyStimulus(1, 32'hFFFFFFFF, 32'h324, 1, 0);
        applyStimulus(1, 32'h00000000, 32'h328, 1, 0);
        applyStimulus(1, ECALL, 32'h32C, 1, 0);
        checkOutput("ecall.op", 64'(a_op), 64'd39);
        checkOutput("ecall.ill", 64'(a_ill), 64'd0);
        applyStimulus(0, 32'd0, 32'd0, 1, 0);
        checkOutput("sat.b_count", 64'(b_cnt), 64'd3);
        checkOutput("sat.a_count", 64'(a_cnt), 64'd4);

        // CSRRWI x1,mstatus,5 then reset during a stall
        applyStimulus(1, CSRRWI, 32'h400, 0, 0);
        checkOutput("csr.op", 64'(a_op), 64'd45);
        checkOutput("csr.imm", 64'(a_imm), 64'h300);
        checkOutput("csr.rs1", 64'(a_rs1), 64'd5);
        checkOutput("csr.we", 64'(a_we), 64'd1);
        checkOutput("csr.b_op", 64'(b_op), 64'd63);
        applyStimulus(1, ADDI, 32'h404, 0, 0);
        i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst.a_valid", 64'(a_valid), 64'd0);
        checkOutput("arst.b_valid", 64'(b_valid), 64'd0);
        checkOutput("arst.ready", 64'(a_ready), 64'd1);
        checkOutput("arst.b_count", 64'(b_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Broader decode coverage with an irregular ready pattern
        foreach (vecs[i])
            applyStimulus(1, vecs[i], 32'h500 + 32'(i * 4), (i % 3) != 2, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 32'd0, 32'd0, 1, 0);
        applyStimulus(0, 32'd0, 32'd0, 1, 1);
        applyStimulus(0, 32'd0, 32'd0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
